// File: rtl/neuromorphic_x1_wb_bank_ctrl.sv
// neuromorphic_x1_wb_bank_ctrl
// Wishbone slave front-end fanning one Wishbone port out to N_BANKS
// Neuromorphic_X1 cores, each behind a req/ack port.
//
// Optional feature macro: NEUROMORPHIC_X1_BANK_TIMEOUT_EN
//   defined   -> request watchdog (16-bit counter, timeout_o pulse)
//   undefined -> no watchdog, timeout_o tied low, REQ/DRAIN wait forever
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone control
//   wbs_adr_i, wbs_dat_i        Wishbone address / write data
//   wbs_dat_o, wbs_ack_o        Wishbone read data / acknowledge
//   bank_req_o                  one-hot bank request
//   bank_we_o/adr_o/dat_o       registered command to the selected bank
//   bank_dat_i, bank_ack_i      per-bank read data (32b slices) / completion
//   timeout_o                   one-cycle watchdog pulse
module neuromorphic_x1_wb_bank_ctrl #(
  parameter int          N_BANKS        = 4,
  parameter int          BANK_SHIFT     = 16,
  parameter int          BW             = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic [31:0]             wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic [N_BANKS-1:0]      bank_req_o,
  output logic                    bank_we_o,
  output logic [BANK_SHIFT-1:0]   bank_adr_o,
  output logic [31:0]             bank_dat_o,
  input  logic [N_BANKS*32-1:0]   bank_dat_i,
  input  logic [N_BANKS-1:0]      bank_ack_i,
  output logic                    timeout_o
);

  localparam int TOP_LSB = BANK_SHIFT + BW;

  if (N_BANKS < 1 || N_BANKS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_param
    $error("neuromorphic_x1_wb_bank_ctrl: N_BANKS or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   idx_q;
  logic [BW-1:0]   adr_idx;
  logic            access, region_hit, bad_bank, part_wr, accept;
  logic            in_req, sel_ack, wd_fire;
  logic [N_BANKS-1:0] sel_mask;
  logic [31:0]     sel_rdata;

  // ---- decode ----
  assign adr_idx    = wbs_adr_i[TOP_LSB-1:BANK_SHIFT];
  assign access     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign region_hit = (wbs_adr_i[31:TOP_LSB] == ADDR_BASE[31:TOP_LSB]);
  assign bad_bank   = (32'(adr_idx) >= 32'(N_BANKS));
  assign part_wr    = wbs_we_i & (wbs_sel_i != 4'hF);
  assign accept     = (state == IDLE) & access & region_hit;

  // One-hot of the latched index; acks/data from other banks are masked off.
  always_comb begin
    sel_mask  = '0;
    sel_rdata = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      sel_mask[k] = (32'(idx_q) == 32'(k));
      if (sel_mask[k]) sel_rdata = bank_dat_i[32*k +: 32];
    end
  end

  assign in_req     = (state == REQ) | (state == DRAIN);
  assign sel_ack    = |(bank_ack_i & sel_mask);
  assign bank_req_o = in_req ? sel_mask : '0;
  assign wbs_ack_o  = (state == RESP);

  // ---- watchdog ----
`ifdef NEUROMORPHIC_X1_BANK_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        timeout_q;

  // Fires at the end of the TIMEOUT_CYCLES-th cycle spent waiting; a
  // bank ack in that same cycle takes priority.
  assign wd_fire   = in_req & ~sel_ack & (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if ((state_nxt != state) && ((state_nxt == REQ) || (state_nxt == DRAIN)))
        wd_cnt <= '0;
      else if (in_req)
        wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // ---- FSM ----
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (part_wr | bad_bank) ? RESP : REQ;
      // Bank ack beats a simultaneous cyc drop; a dropped cycle gets no ack.
      REQ:   if (sel_ack)         state_nxt = wbs_cyc_i ? RESP : IDLE;
             else if (wd_fire)    state_nxt = RESP;
             else if (!wbs_cyc_i) state_nxt = DRAIN;
      // Core ops cannot be aborted: keep requesting until the bank finishes.
      DRAIN: if (sel_ack | wd_fire) state_nxt = IDLE;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      idx_q      <= '0;
      bank_we_o  <= 1'b0;
      bank_adr_o <= '0;
      bank_dat_o <= '0;
      wbs_dat_o  <= '0;
    end else begin
      if (accept) begin
        idx_q      <= adr_idx;
        bank_we_o  <= wbs_we_i;
        bank_adr_o <= wbs_adr_i[BANK_SHIFT-1:0];
        bank_dat_o <= wbs_dat_i;
        // Locally answered accesses: invalid-bank reads return a tagged
        // error word, dropped writes return 0.
        if (part_wr | bad_bank)
          wbs_dat_o <= (bad_bank & ~wbs_we_i) ? (32'hBAD0_0000 | 32'(adr_idx)) : 32'h0;
      end
      if (state == REQ) begin
        if (sel_ack & wbs_cyc_i) wbs_dat_o <= bank_we_o ? 32'h0 : sel_rdata;
        else if (!sel_ack & wd_fire) wbs_dat_o <= 32'hFFFF_FFFF;
      end
    end
  end

endmodule
